// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types and constants for the fetch controller:
//                FSM state encoding, redirect-source encoding, address width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package fetch_ctrl_pkg;

    // Address width shared by pc, fetch address and redirect targets
    localparam int unsigned FC_PC_WIDTH = `PC_WIDTH;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_RUN   = 2'd1,
        FC_DRAIN = 2'd2
    } fc_state_e;

    // Which redirect source won arbitration (informational)
    typedef enum logic [1:0] {
        RS_NONE = 2'd0,
        RS_CTRL = 2'd1,
        RS_BR   = 2'd2,
        RS_JP   = 2'd3
    } redir_src_e;

    // Fixed-priority pick: trap/mret beats branch beats jump
    function automatic redir_src_e fc_pick_src(input logic ctrl_req,
                                               input logic br_req,
                                               input logic jp_req);
        redir_src_e src;
        src = RS_NONE;
        if (ctrl_req) begin
            src = RS_CTRL;
        end else if (br_req) begin
            src = RS_BR;
        end else if (jp_req) begin
            src = RS_JP;
        end
        return src;
    endfunction

endpackage : fetch_ctrl_pkg

`default_nettype wire

// File: rtl/fetch_ctrl_redirect_arb.sv
// ============================================================================
//  Module      : redirect_arb
//  Description : Purely combinational priority select of the redirect target.
//                trap|mret > branch > jump. The valid is qualified by the
//                global enable; the address follows the winning request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module redirect_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH = FC_PC_WIDTH
) (
    input  logic                cpu_en_i,
    input  logic                trap_happened_i,
    input  logic                mret_en_i,
    input  logic [PC_WIDTH-1:0] ctrl_pc_i,
    input  logic                br_taken_i,
    input  logic [PC_WIDTH-1:0] br_addr_i,
    input  logic                jp_taken_i,
    input  logic [PC_WIDTH-1:0] jp_addr_i,
    output logic                redirect_valid_o,
    output logic [PC_WIDTH-1:0] redirect_addr_o
);

    redir_src_e w_src;

    assign w_src = fc_pick_src(trap_happened_i | mret_en_i, br_taken_i, jp_taken_i);

    // Mux the winner's target; zero when nobody is asking
    always_comb begin
        redirect_addr_o  = '0;
        redirect_valid_o = (w_src != RS_NONE) & cpu_en_i;
        case (w_src)
            RS_CTRL: redirect_addr_o = ctrl_pc_i;
            RS_BR:   redirect_addr_o = br_addr_i;
            RS_JP:   redirect_addr_o = jp_addr_i;
            default: redirect_addr_o = '0;
        endcase
    end

endmodule : redirect_arb

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch sequencer in front of the pc register and the imem
//                fetch port. Arbitrates redirects, issues in-order fetch
//                requests, tracks up to MAX_OUTST in-flight fetches and
//                squashes responses that belong to the wrong path.
//  Options     : `define FETCH_PERF_CNT_EN adds redirect_count and
//                discard_count 32-bit performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = FC_PC_WIDTH,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned CNT_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_en,
    input  logic                backend_stall,
    input  logic                trap_happened,
    input  logic                mret_en,
    input  logic [PC_WIDTH-1:0] ctrl_pc,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_addr,
    input  logic                jp_taken,
    input  logic [PC_WIDTH-1:0] jp_addr,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    output logic                pc_stall,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_addr,
    output logic                if_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         redirect_count,
    output logic [31:0]         discard_count,
`endif
    output logic                flush_fetch
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OUTST);

    fc_state_e            state_q;
    logic [CNT_W-1:0]     outst_q;
    logic [CNT_W-1:0]     outst_d;
    logic [CNT_W-1:0]     discard_q;
    logic                 flush_q;

    logic                 w_arb_valid;
    logic [PC_WIDTH-1:0]  w_arb_addr;
    logic                 w_req_fire;
    logic                 w_rsp_fire;
    logic [CNT_W-1:0]     w_inflight;

    redirect_arb #(
        .PC_WIDTH (PC_WIDTH)
    ) u_redirect_arb (
        .cpu_en_i         (cpu_en),
        .trap_happened_i  (trap_happened),
        .mret_en_i        (mret_en),
        .ctrl_pc_i        (ctrl_pc),
        .br_taken_i       (br_taken),
        .br_addr_i        (br_addr),
        .jp_taken_i       (jp_taken),
        .jp_addr_i        (jp_addr),
        .redirect_valid_o (w_arb_valid),
        .redirect_addr_o  (w_arb_addr)
    );

    // Outputs are forced to zero while reset is held
    assign redirect_valid = w_arb_valid & rst_n;
    assign redirect_addr  = rst_n ? w_arb_addr : '0;
    assign imem_req_addr  = rst_n ? pc : '0;

    assign imem_req_valid = (state_q == FC_RUN) & ~backend_stall & ~redirect_valid
                          & (outst_q < C_MAX_CNT);
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign pc_stall       = rst_n & ~w_req_fire;

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp_fire     = imem_rsp_valid & (outst_q != '0);

    // Fetches still owed after this cycle's response (no accept can coincide
    // with a redirect, so only the response matters here)
    assign w_inflight     = outst_q - CNT_W'(w_rsp_fire);

    assign if_valid       = imem_rsp_valid & (state_q == FC_RUN) & ~redirect_valid
                          & (discard_q == '0);
    assign flush_fetch    = flush_q;

    // Next outstanding count: accept adds one, response removes one
    always_comb begin
        outst_d = outst_q;
        case ({w_req_fire, w_rsp_fire})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Outstanding fetch counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    // Sequencer FSM with discard counter and registered flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FC_IDLE;
            discard_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= redirect_valid;
            case (state_q)
                FC_IDLE: begin
                    if (cpu_en) begin
                        state_q <= FC_RUN;
                    end
                end
                FC_RUN: begin
                    if (redirect_valid && (w_inflight != '0)) begin
                        state_q   <= FC_DRAIN;
                        discard_q <= w_inflight;
                    end else if (!cpu_en && (outst_q == '0)) begin
                        state_q <= FC_IDLE;
                    end
                end
                FC_DRAIN: begin
                    if (redirect_valid) begin
                        // Everything still in flight is stale again
                        discard_q <= w_inflight;
                        if (w_inflight == '0) begin
                            state_q <= FC_RUN;
                        end
                    end else if (w_rsp_fire && (discard_q != '0)) begin
                        discard_q <= discard_q - CNT_W'(1);
                        if (discard_q == CNT_W'(1)) begin
                            state_q <= FC_RUN;
                        end
                    end
                end
                default: begin
                    state_q   <= FC_IDLE;
                    discard_q <= '0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] discard_cnt_q;

    assign redirect_count = redirect_cnt_q;
    assign discard_count  = discard_cnt_q;

    // Free-running wrap-around counters of redirects and dropped responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            discard_cnt_q  <= '0;
        end else begin
            if (redirect_valid) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (w_rsp_fire && !if_valid) begin
                discard_cnt_q <= discard_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_ctrl

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. A transaction-level
//                model (queue of in-flight fetches tagged stale/fresh) runs
//                alongside the DUT; directed tables, hand sequences and a
//                random phase are all checked against it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam int PW   = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cpu_en, backend_stall, trap_happened, mret_en;
    logic          br_taken, jp_taken, imem_req_ready, imem_rsp_valid;
    logic [PW-1:0] ctrl_pc, br_addr, jp_addr, pc;
    logic          imem_req_valid, pc_stall, redirect_valid, if_valid, flush_fetch;
    logic [PW-1:0] imem_req_addr, redirect_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   redirect_count, discard_count;
`endif

    fetch_ctrl #(.PC_WIDTH(PW), .MAX_OUTST(MAXO), .CNT_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_en         (cpu_en),
        .backend_stall  (backend_stall),
        .trap_happened  (trap_happened),
        .mret_en        (mret_en),
        .ctrl_pc        (ctrl_pc),
        .br_taken       (br_taken),
        .br_addr        (br_addr),
        .jp_taken       (jp_taken),
        .jp_addr        (jp_addr),
        .pc             (pc),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .pc_stall       (pc_stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .if_valid       (if_valid),
`ifdef FETCH_PERF_CNT_EN
        .redirect_count (redirect_count),
        .discard_count  (discard_count),
`endif
        .flush_fetch    (flush_fetch)
    );

    // ---------------- reference model state ----------------
    bit          mq[$];        // in-flight fetches, 1 = wrong path
    bit          m_active;     // sequencer out of idle
    bit          m_flush;
    logic [31:0] m_pc;
    int unsigned m_redir_cnt, m_disc_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          req_valid;
        logic [PW-1:0] req_addr;
        logic          stall;
        logic          rv;
        logic [PW-1:0] ra;
        logic          ifv;
        logic          flush;
    } outs_t;

    outs_t cur;

    function automatic int n_stale();
        int n = 0;
        foreach (mq[i]) if (mq[i]) n++;
        return n;
    endfunction

    function automatic outs_t model_outs();
        outs_t e;
        bit    running;
        running  = m_active && (n_stale() == 0);
        e.ra     = '0;
        if (trap_happened || mret_en) e.ra = ctrl_pc;
        else if (br_taken)            e.ra = br_addr;
        else if (jp_taken)            e.ra = jp_addr;
        e.rv        = rst_n && cpu_en && (trap_happened || mret_en || br_taken || jp_taken);
        e.req_valid = rst_n && running && !backend_stall && !e.rv && (mq.size() < MAXO);
        e.req_addr  = rst_n ? pc : '0;
        e.stall     = rst_n && !(e.req_valid && imem_req_ready);
        e.ifv       = rst_n && imem_rsp_valid && running && !e.rv;
        e.flush     = rst_n && m_flush;
        if (!rst_n) e.ra = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Let inputs settle, then compare every output against the model
    task automatic settle();
        #1;
        cur = model_outs();
        chk("imem_req_valid", 64'(imem_req_valid), 64'(cur.req_valid));
        chk("imem_req_addr",  64'(imem_req_addr),  64'(cur.req_addr));
        chk("pc_stall",       64'(pc_stall),       64'(cur.stall));
        chk("redirect_valid", 64'(redirect_valid), 64'(cur.rv));
        chk("redirect_addr",  64'(redirect_addr),  64'(cur.ra));
        chk("if_valid",       64'(if_valid),       64'(cur.ifv));
        chk("flush_fetch",    64'(flush_fetch),    64'(cur.flush));
`ifdef FETCH_PERF_CNT_EN
        chk("redirect_count", 64'(redirect_count), 64'(m_redir_cnt));
        chk("discard_count",  64'(discard_count),  64'(m_disc_cnt));
`endif
    endtask

    // Advance one clock: update the model with this cycle's inputs
    task automatic tick();
        bit was_empty, accept;
        int st;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_active = 0; m_flush = 0; m_pc = '0;
            m_redir_cnt = 0; m_disc_cnt = 0;
        end else begin
            was_empty = (mq.size() == 0);
            st        = n_stale();
            accept    = cur.req_valid && imem_req_ready;
            m_flush   = cur.rv;
            if (cur.rv) m_redir_cnt++;
            if (imem_rsp_valid && mq.size() > 0) begin
                void'(mq.pop_front());
                if (!cur.ifv) m_disc_cnt++;
            end
            if (cur.rv) foreach (mq[i]) mq[i] = 1'b1;
            if (accept) mq.push_back(1'b0);
            if (!m_active) m_active = cpu_en;
            else if (st == 0 && !cpu_en && was_empty) m_active = 0;
            m_pc = cur.rv ? cur.ra : (accept ? m_pc + 32'd4 : m_pc);
        end
        @(negedge clk);
        pc = m_pc;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic quiet();
        trap_happened = 0; mret_en = 0; br_taken = 0; jp_taken = 0;
        backend_stall = 0; imem_rsp_valid = 0;
    endtask

    // Directed arbitration vectors
    typedef struct {
        bit          tr, mr, br, jp, en;
        logic [31:0] ca, ba, ja;
        bit          ev;
        bit          chk_addr;
        logic [31:0] ea;
    } arb_vec_t;

    arb_vec_t tbl[8];

    initial begin
        rst_n = 0; cpu_en = 0; imem_req_ready = 0; pc = '0;
        ctrl_pc = '0; br_addr = '0; jp_addr = '0;
        quiet();
        m_pc = '0; m_active = 0; m_flush = 0; m_redir_cnt = 0; m_disc_cnt = 0;

        tbl[0] = '{0,0,0,0,1, 32'h80,  32'h100, 32'h200, 0, 1, 32'h0};
        tbl[1] = '{1,0,1,0,1, 32'h80,  32'h100, 32'h200, 1, 1, 32'h80};
        tbl[2] = '{0,1,0,0,1, 32'h44,  32'h100, 32'h200, 1, 1, 32'h44};
        tbl[3] = '{0,0,1,1,1, 32'h80,  32'h100, 32'h200, 1, 1, 32'h100};
        tbl[4] = '{0,0,0,1,1, 32'h80,  32'h100, 32'h204, 1, 1, 32'h204};
        tbl[5] = '{1,0,0,0,0, 32'h80,  32'h100, 32'h200, 0, 0, 32'h0};
        tbl[6] = '{0,1,0,1,1, 32'h90,  32'h100, 32'h200, 1, 1, 32'h90};
        tbl[7] = '{1,1,1,1,1, 32'hA0,  32'h100, 32'h200, 1, 1, 32'hA0};

        // ---- reset: every output low ----
        @(negedge clk);
        settle();
        chk("reset_outputs", 64'({imem_req_valid, imem_req_addr, pc_stall, redirect_valid,
                                  redirect_addr, if_valid, flush_fetch}), 64'd0);
        tick();
        rst_n = 1;
        step();

        // ---- sequential fetch 0x0, 0x4, 0x8, 0xC; response one cycle later ----
        cpu_en = 1; imem_req_ready = 1;
        step();                                   // IDLE -> RUN
        for (int k = 0; k < 4; k++) begin
            imem_rsp_valid = (k > 0);
            settle();
            chk("seq_req_addr", 64'(imem_req_addr), 64'(4 * k));
            chk("seq_pc_stall", 64'(pc_stall), 64'd0);
            chk("seq_if_valid", 64'(if_valid), 64'(k > 0));
            tick();
        end
        imem_rsp_valid = 1; imem_req_ready = 0;
        step();                                   // last response
        imem_rsp_valid = 0;

        // ---- imem not ready for 3 cycles ----
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("stall_pc_stall", 64'(pc_stall), 64'd1);
            chk("stall_req_addr", 64'(imem_req_addr), 64'h10);
            tick();
        end

        // ---- two in flight, branch to 0x100 ----
        imem_req_ready = 1;
        step(); step();                           // accept 0x10, 0x14
        settle();
        chk("max_outst_block", 64'(imem_req_valid), 64'd0);
        tick();
        br_taken = 1; br_addr = 32'h100;
        settle();
        chk("br_redirect_addr", 64'(redirect_addr), 64'h100);
        tick();
        br_taken = 0; imem_rsp_valid = 1;
        settle();
        chk("br_flush_pulse", 64'(flush_fetch), 64'd1);
        chk("br_drop1", 64'(if_valid), 64'd0);
        tick();
        settle();
        chk("br_flush_once", 64'(flush_fetch), 64'd0);
        chk("br_drop2", 64'(if_valid), 64'd0);
        chk("br_no_req_drain", 64'(imem_req_valid), 64'd0);
        tick();
        imem_rsp_valid = 0;
        settle();
        chk("br_resume_valid", 64'(imem_req_valid), 64'd1);
        chk("br_resume_addr", 64'(imem_req_addr), 64'h100);
        tick();
        imem_rsp_valid = 1; imem_req_ready = 0;
        settle();
        chk("br_newpath_fwd", 64'(if_valid), 64'd1);
        tick();
        imem_rsp_valid = 0;

        // ---- arbitration table ----
        backend_stall = 1;
        for (int i = 0; i < 8; i++) begin
            trap_happened = tbl[i].tr; mret_en = tbl[i].mr;
            br_taken = tbl[i].br; jp_taken = tbl[i].jp; cpu_en = tbl[i].en;
            ctrl_pc = tbl[i].ca; br_addr = tbl[i].ba; jp_addr = tbl[i].ja;
            settle();
            chk("arb_valid", 64'(redirect_valid), 64'(tbl[i].ev));
            if (tbl[i].chk_addr) chk("arb_addr", 64'(redirect_addr), 64'(tbl[i].ea));
            tick();
        end
        quiet(); cpu_en = 1;
        step();

        // ---- trap beats branch; 1-cycle latency with nothing in flight ----
        trap_happened = 1; ctrl_pc = 32'h80; br_taken = 1; br_addr = 32'h100;
        settle();
        chk("trap_prio_addr", 64'(redirect_addr), 64'h80);
        tick();
        quiet();
        settle();
        chk("trap_lat_valid", 64'(imem_req_valid), 64'd1);
        chk("trap_lat_addr", 64'(imem_req_addr), 64'h80);
        tick();

        // ---- redirect while draining reloads discard count ----
        imem_req_ready = 1;
        step(); step();                           // 0x80, 0x84 in flight
        imem_req_ready = 0; br_taken = 1; br_addr = 32'h300;
        step();                                   // DRAIN with 2 stale
        br_taken = 0; jp_taken = 1; jp_addr = 32'h200; imem_rsp_valid = 1;
        settle();
        chk("drain_jp_addr", 64'(redirect_addr), 64'h200);
        chk("drain_jp_drop", 64'(if_valid), 64'd0);
        tick();
        quiet();
        settle();
        chk("drain_still", 64'(imem_req_valid), 64'd0);
        tick();
        imem_rsp_valid = 1;
        settle();
        chk("drain_last_drop", 64'(if_valid), 64'd0);
        tick();
        imem_rsp_valid = 0;
        settle();
        chk("drain_resume_addr", 64'(imem_req_addr), 64'h200);
        chk("drain_resume_valid", 64'(imem_req_valid), 64'd1);
        tick();

        // ---- reset while draining; late response ignored ----
        imem_req_ready = 1;
        step(); step();
        imem_req_ready = 0; br_taken = 1; br_addr = 32'h400;
        step();
        quiet(); rst_n = 0;
        settle();
        chk("rst_drain_zero", 64'({imem_req_valid, pc_stall, redirect_valid, if_valid, flush_fetch}), 64'd0);
        tick();
        rst_n = 1; cpu_en = 0; imem_rsp_valid = 1;
        settle();
        chk("late_rsp_ignored", 64'(if_valid), 64'd0);
        tick();
        imem_rsp_valid = 0; cpu_en = 1;
        step();
        settle();
        chk("post_rst_req", 64'(imem_req_valid), 64'd1);
        chk("post_rst_addr", 64'(imem_req_addr), 64'h0);
        tick();
        jp_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            jp_taken = 1;
            step();
        end
        jp_taken = 0;
        settle();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_redirects", 64'(redirect_count), 64'd3);
`endif
        tick();

        // ---- randomized run against the model ----
        rst_n = 0; step(); rst_n = 1;
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 599) != 0);
            cpu_en         = ($urandom_range(0, 15) != 0);
            backend_stall  = ($urandom_range(0, 4) == 0);
            trap_happened  = ($urandom_range(0, 39) == 0);
            mret_en        = ($urandom_range(0, 39) == 0);
            br_taken       = ($urandom_range(0, 11) == 0);
            jp_taken       = ($urandom_range(0, 11) == 0);
            ctrl_pc        = $urandom & 32'hFFFF_FFFC;
            br_addr        = $urandom & 32'hFFFF_FFFC;
            jp_addr        = $urandom & 32'hFFFF_FFFC;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_valid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_ctrl

`default_nettype wire
